// File: rtl/sb_9_chany_drv_if.sv
// sb_9_chany_drv_if: configuration-chain and routing-track bundle for the
// vertical switch-block driver. The master side drives the configuration
// chain and the incoming tracks; the slave side is the driver itself.
interface sb_9_chany_drv_if #(
    parameter int NUM_TRACKS = 64
);
    logic                  config_enable;
    logic                  ccff_head;
    logic                  ccff_tail;
    logic                  config_done;
    logic [0:NUM_TRACKS-1] chany_top_in;
    logic [0:NUM_TRACKS-1] chany_bottom_out;

    modport master (
        output config_enable,
        output ccff_head,
        output chany_top_in,
        input  ccff_tail,
        input  config_done,
        input  chany_bottom_out
    );

    modport slave (
        input  config_enable,
        input  ccff_head,
        input  chany_top_in,
        output ccff_tail,
        output config_done,
        output chany_bottom_out
    );
endinterface

// File: rtl/sb_9_chany_drv.sv
// sb_9_chany_drv: vertical-channel switch-block driver.
// A serial configuration chain (ccff_head -> mem[0] ... mem[CFG_LEN-1] ->
// ccff_tail) holds a 2-bit select per track. Each track selects its own
// input, its upper neighbour, its lower neighbour (indices wrap), or a
// constant 0. Outputs are held at 0 while the chain is shifting.
// Build option: define SB_CHANY_OUTPUT_REG_EN to register chany_bottom_out
// (one cycle latency); otherwise the output stage is combinational.
module sb_9_chany_drv #(
    parameter int NUM_TRACKS = 64,
    parameter int SEL_BITS   = 2
) (
    input  logic                    prog_clk,
    input  logic                    pReset,
    sb_9_chany_drv_if.slave         bus
);

    localparam int         CFG_LEN   = NUM_TRACKS * SEL_BITS;
    localparam logic [7:0] CFG_LEN_C = 8'(CFG_LEN);

    logic [CFG_LEN-1:0]    mem_q;
    logic [CFG_LEN-1:0]    mem_d;
    logic [7:0]            cnt_q;
    logic [7:0]            cnt_d;
    logic                  done_q;
    logic                  done_d;
    logic [0:NUM_TRACKS-1] route_s;

    // Next-state for the chain, the saturating shift counter and the done flag.
    always_comb begin
        mem_d  = mem_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        if (bus.config_enable) begin
            mem_d = {mem_q[CFG_LEN-2:0], bus.ccff_head};
            if (cnt_q != CFG_LEN_C) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            mem_d = mem_q;
            cnt_d = cnt_q;
        end
        done_d = (cnt_d == CFG_LEN_C);
    end

    // Configuration state registers; reset aborts any partial load.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            mem_q  <= '0;
            cnt_q  <= 8'd0;
            done_q <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // Per-track multiplexer driven by the decoded select pair of each track.
    always_comb begin
        route_s = '0;
        for (int i = 0; i < NUM_TRACKS; i++) begin
            case (mem_q[SEL_BITS*i +: 2])
                2'd0:    route_s[i] = bus.chany_top_in[i];
                2'd1:    route_s[i] = bus.chany_top_in[(i + 1) % NUM_TRACKS];
                2'd2:    route_s[i] = bus.chany_top_in[(i + NUM_TRACKS - 1) % NUM_TRACKS];
                default: route_s[i] = 1'b0;
            endcase
        end
    end

`ifdef SB_CHANY_OUTPUT_REG_EN
    logic [0:NUM_TRACKS-1] out_q;

    // Registered output stage; blanked while shifting or in reset.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            out_q <= '0;
        end else if (bus.config_enable) begin
            out_q <= '0;
        end else begin
            out_q <= route_s;
        end
    end

    assign bus.chany_bottom_out = out_q;
`else
    logic [0:NUM_TRACKS-1] out_s;

    // Combinational output stage; blanked while shifting or in reset.
    always_comb begin
        out_s = '0;
        if (pReset || bus.config_enable) begin
            out_s = '0;
        end else begin
            out_s = route_s;
        end
    end

    assign bus.chany_bottom_out = out_s;
`endif

    assign bus.ccff_tail   = mem_q[CFG_LEN-1];
    assign bus.config_done = done_q;

endmodule
